// File: rtl/tour_sequencer.sv
// tour_sequencer: shares the cmd_proc port between the UART stream and TourCmd.
// Define SOLVE_WDOG_EN to add a solver watchdog that aborts after SOLVE_TO cycles.
module tour_sequencer #(
    parameter int         NUM_MOVES     = 24,
    parameter int         CMDS_PER_MOVE = 2,
    parameter logic [3:0] TOUR_OP       = 4'h6,
    parameter logic [3:0] ABORT_OP      = 4'hF
`ifdef SOLVE_WDOG_EN
    ,
    parameter int         SOLVE_TO      = 2**20
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    input  logic [15:0] tcmd,
    input  logic        tcmd_rdy,
    output logic        clr_tcmd_rdy,
    output logic        tsend_resp,
    output logic        start_solve,
    output logic [2:0]  x_start,
    output logic [2:0]  y_start,
    input  logic        solve_done,
    output logic        start_tour,
    output logic        tour_abort,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        resp_vld,
    output logic        busy
);

    localparam logic [5:0] TOTAL    = 6'(NUM_MOVES * CMDS_PER_MOVE);
    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_MOV = 8'h5A;
    localparam logic [7:0] RESP_ABT = 8'hEE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SOLVE = 2'd1,
        TOUR  = 2'd2
    } state_t;

    state_t     state;
    logic [5:0] move_cnt;

`ifdef SOLVE_WDOG_EN
    localparam logic [20:0] WDOG_LAST = 21'(SOLVE_TO - 1);
    logic [20:0] wdog_cnt;
    logic        wdog_to;
    assign wdog_to = (wdog_cnt == WDOG_LAST);
`endif

    logic is_tour;
    logic is_abort;
    logic special;
    logic abort_req;
    logic tour_req;
    logic last_resp;

    assign is_tour   = (cmd_UART[15:12] == TOUR_OP);
    assign is_abort  = (cmd_UART[15:12] == ABORT_OP);
    assign special   = is_tour | is_abort;
    assign abort_req = cmd_rdy_UART & is_abort;
    assign tour_req  = cmd_rdy_UART & is_tour;
    assign last_resp = send_resp && ((move_cnt + 6'd1) >= TOTAL);

    // Source mux; the final move response beats a same-cycle abort.
    always_comb begin
        cmd              = cmd_UART;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        clr_tcmd_rdy     = 1'b0;
        tsend_resp       = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_rdy          = cmd_rdy_UART & ~special;
                clr_cmd_rdy_UART = cmd_rdy_UART & (special | clr_cmd_rdy);
            end
            SOLVE: begin
                clr_cmd_rdy_UART = abort_req;
            end
            TOUR: begin
                cmd              = tcmd;
                cmd_rdy          = tcmd_rdy;
                clr_tcmd_rdy     = clr_cmd_rdy & tcmd_rdy;
                tsend_resp       = send_resp;
                clr_cmd_rdy_UART = abort_req & ~last_resp;
            end
            default: begin
                cmd_rdy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            move_cnt    <= 6'd0;
            x_start     <= 3'd0;
            y_start     <= 3'd0;
            start_solve <= 1'b0;
            start_tour  <= 1'b0;
            tour_abort  <= 1'b0;
            resp        <= 8'h00;
            resp_vld    <= 1'b0;
            busy        <= 1'b0;
`ifdef SOLVE_WDOG_EN
            wdog_cnt    <= 21'd0;
`endif
        end else begin
            start_solve <= 1'b0;
            start_tour  <= 1'b0;
            tour_abort  <= 1'b0;
            resp_vld    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (send_resp) begin
                        resp     <= RESP_ACK;
                        resp_vld <= 1'b1;
                    end
                    if (abort_req) begin
                        resp     <= RESP_ABT;
                        resp_vld <= 1'b1;
                    end else if (tour_req) begin
                        x_start     <= cmd_UART[6:4];
                        y_start     <= cmd_UART[2:0];
                        start_solve <= 1'b1;
                        busy        <= 1'b1;
                        state       <= SOLVE;
`ifdef SOLVE_WDOG_EN
                        wdog_cnt    <= 21'd0;
`endif
                    end
                end
                SOLVE: begin
`ifdef SOLVE_WDOG_EN
                    wdog_cnt <= wdog_cnt + 21'd1;
`endif
                    if (abort_req) begin
                        tour_abort <= 1'b1;
                        resp       <= RESP_ABT;
                        resp_vld   <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (solve_done) begin
                        start_tour <= 1'b1;
                        move_cnt   <= 6'd0;
                        state      <= TOUR;
`ifdef SOLVE_WDOG_EN
                    end else if (wdog_to) begin
                        tour_abort <= 1'b1;
                        resp       <= RESP_ABT;
                        resp_vld   <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
`endif
                    end
                end
                TOUR: begin
                    if (last_resp) begin
                        move_cnt <= TOTAL;
                        resp     <= RESP_ACK;
                        resp_vld <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (abort_req) begin
                        tour_abort <= 1'b1;
                        resp       <= RESP_ABT;
                        resp_vld   <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (send_resp) begin
                        move_cnt <= move_cnt + 6'd1;
                        resp     <= RESP_MOV;
                        resp_vld <= 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tour_sequencer.sv
// Directed bench for tour_sequencer: UART forwarding, tours, aborts, reset.
// Define SOLVE_WDOG_EN to exercise the watchdog with a 100-cycle limit.
module tb_tour_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic [15:0] tcmd;
    logic        tcmd_rdy;
    logic        clr_tcmd_rdy;
    logic        tsend_resp;
    logic        start_solve;
    logic [2:0]  x_start;
    logic [2:0]  y_start;
    logic        solve_done;
    logic        start_tour;
    logic        tour_abort;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        resp_vld;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef SOLVE_WDOG_EN
    tour_sequencer #(.SOLVE_TO(100)) dut (
`else
    tour_sequencer dut (
`endif
        .clk(clk), .rst(rst),
        .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
        .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
        .tcmd(tcmd), .tcmd_rdy(tcmd_rdy),
        .clr_tcmd_rdy(clr_tcmd_rdy), .tsend_resp(tsend_resp),
        .start_solve(start_solve), .x_start(x_start), .y_start(y_start),
        .solve_done(solve_done), .start_tour(start_tour),
        .tour_abort(tour_abort), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
        .resp(resp), .resp_vld(resp_vld), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic go_tour(input logic [15:0] c);
        cmd_UART     = c;
        cmd_rdy_UART = 1'b1;
        nxt();
        cmd_rdy_UART = 1'b0;
        solve_done   = 1'b1;
        nxt();
        solve_done   = 1'b0;
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n; i++) begin
            send_resp = 1'b1;
            nxt();
        end
        send_resp = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cmd_UART = 16'h0; cmd_rdy_UART = 1'b0;
        tcmd = 16'h0; tcmd_rdy = 1'b0;
        solve_done = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        nxt();
        nxt();
        check("rst_busy", busy, 1'b0);
        check("rst_resp", resp, 8'h00);
        check("rst_vld", resp_vld, 1'b0);
        check("rst_xy", {x_start, y_start}, 6'd0);
        check("rst_abort", tour_abort, 1'b0);
        rst = 1'b0;

        // plain UART command forwarded in IDLE
        cmd_UART = 16'h2400; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1;
        @(negedge clk);
        check("fwd_cmd", cmd, 16'h2400);
        check("fwd_rdy", cmd_rdy, 1'b1);
        check("fwd_clr", clr_cmd_rdy_UART, 1'b1);
        nxt();
        cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b0;
        send_resp = 1'b1;
        nxt();
        send_resp = 1'b0;
        check("idle_resp", resp, 8'hA5);
        check("idle_vld", resp_vld, 1'b1);
        nxt();
        check("idle_vld_off", resp_vld, 1'b0);

        // tour go
        cmd_UART = 16'h6032; cmd_rdy_UART = 1'b1;
        @(negedge clk);
        check("go_rdy", cmd_rdy, 1'b0);
        check("go_clr", clr_cmd_rdy_UART, 1'b1);
        check("go_ss_early", start_solve, 1'b0);
        nxt();
        cmd_rdy_UART = 1'b0;
        check("go_ss", start_solve, 1'b1);
        check("go_x", x_start, 3'd3);
        check("go_y", y_start, 3'd2);
        check("go_busy", busy, 1'b1);

        // UART command queued during SOLVE stays pending
        cmd_UART = 16'h2400; cmd_rdy_UART = 1'b1;
        @(negedge clk);
        check("solve_clr", clr_cmd_rdy_UART, 1'b0);
        check("solve_rdy", cmd_rdy, 1'b0);
        nxt();
        check("solve_ss_off", start_solve, 1'b0);
        solve_done = 1'b1;
        nxt();
        solve_done = 1'b0;
        check("tour_start", start_tour, 1'b1);
        check("tour_busy", busy, 1'b1);

        tcmd = 16'h4001; tcmd_rdy = 1'b1; clr_cmd_rdy = 1'b1;
        for (int i = 0; i < 48; i++) begin
            send_resp = 1'b1;
            @(negedge clk);
            if (i == 0) begin
                check("tour_cmd", cmd, 16'h4001);
                check("tour_rdy", cmd_rdy, 1'b1);
                check("tour_tclr", clr_tcmd_rdy, 1'b1);
                check("tour_tsend", tsend_resp, 1'b1);
                check("tour_uclr", clr_cmd_rdy_UART, 1'b0);
            end
            nxt();
            check("tour_vld", resp_vld, 1'b1);
            check("tour_resp", resp, (i < 47) ? 8'h5A : 8'hA5);
        end
        send_resp = 1'b0; tcmd_rdy = 1'b0; clr_cmd_rdy = 1'b0;
        check("done_busy", busy, 1'b0);
        check("done_cnt", dut.move_cnt, 6'd48);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        check("pend_cmd", cmd, 16'h2400);
        check("pend_rdy", cmd_rdy, 1'b1);
        check("pend_clr", clr_cmd_rdy_UART, 1'b1);
        nxt();
        cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b0;

        // abort after 10 moves
        go_tour(16'h6071);
        check("ab_x", x_start, 3'd7);
        check("ab_y", y_start, 3'd1);
        send_n(10);
        cmd_UART = 16'hF000; cmd_rdy_UART = 1'b1;
        @(negedge clk);
        check("ab_clr", clr_cmd_rdy_UART, 1'b1);
        nxt();
        cmd_rdy_UART = 1'b0;
        check("ab_pulse", tour_abort, 1'b1);
        check("ab_resp", resp, 8'hEE);
        check("ab_vld", resp_vld, 1'b1);
        check("ab_busy", busy, 1'b0);
        check("ab_cnt", dut.move_cnt, 6'd10);
        nxt();
        check("ab_pulse_off", tour_abort, 1'b0);
        cmd_UART = 16'h2400; cmd_rdy_UART = 1'b1;
        @(negedge clk);
        check("ab_fwd_rdy", cmd_rdy, 1'b1);
        check("ab_fwd_cmd", cmd, 16'h2400);
        nxt();
        cmd_rdy_UART = 1'b0;

        // abort in IDLE
        cmd_UART = 16'hF000; cmd_rdy_UART = 1'b1;
        @(negedge clk);
        check("iab_clr", clr_cmd_rdy_UART, 1'b1);
        check("iab_rdy", cmd_rdy, 1'b0);
        nxt();
        cmd_rdy_UART = 1'b0;
        check("iab_resp", resp, 8'hEE);
        check("iab_vld", resp_vld, 1'b1);
        check("iab_pulse", tour_abort, 1'b0);

        // abort together with the final send_resp
        go_tour(16'h6000);
        send_n(47);
        check("race_47", resp, 8'h5A);
        send_resp = 1'b1; cmd_UART = 16'hF000; cmd_rdy_UART = 1'b1;
        @(negedge clk);
        check("race_clr", clr_cmd_rdy_UART, 1'b0);
        nxt();
        send_resp = 1'b0;
        check("race_resp", resp, 8'hA5);
        check("race_pulse", tour_abort, 1'b0);
        check("race_busy", busy, 1'b0);
        @(negedge clk);
        check("race_iclr", clr_cmd_rdy_UART, 1'b1);
        nxt();
        cmd_rdy_UART = 1'b0;
        check("race_eresp", resp, 8'hEE);
        check("race_evld", resp_vld, 1'b1);

        // solve_done outside SOLVE
        solve_done = 1'b1;
        nxt();
        solve_done = 1'b0;
        check("sd_idle_st", start_tour, 1'b0);
        check("sd_idle_busy", busy, 1'b0);

        // watchdog / indefinite wait in SOLVE
        cmd_UART = 16'h6000; cmd_rdy_UART = 1'b1;
        nxt();
        cmd_rdy_UART = 1'b0;
        check("wd_ss", start_solve, 1'b1);
`ifdef SOLVE_WDOG_EN
        begin
            logic early;
            early = 1'b0;
            for (int k = 1; k < 100; k++) begin
                nxt();
                early = early | tour_abort;
            end
            check("wd_early", early, 1'b0);
            nxt();
            check("wd_pulse", tour_abort, 1'b1);
            check("wd_resp", resp, 8'hEE);
            check("wd_vld", resp_vld, 1'b1);
            check("wd_busy", busy, 1'b0);
        end
`else
        repeat (150) nxt();
        check("nowd_busy", busy, 1'b1);
        check("nowd_pulse", tour_abort, 1'b0);
        cmd_UART = 16'hF000; cmd_rdy_UART = 1'b1;
        nxt();
        cmd_rdy_UART = 1'b0;
        check("nowd_abort", tour_abort, 1'b1);
        check("nowd_resp", resp, 8'hEE);
`endif

        // reset mid-TOUR
        go_tour(16'h6055);
        send_n(5);
        check("mrst_pre", dut.move_cnt, 6'd5);
        send_resp = 1'b1; rst = 1'b1;
        nxt();
        rst = 1'b0; send_resp = 1'b0;
        check("mrst_vld", resp_vld, 1'b0);
        check("mrst_resp", resp, 8'h00);
        check("mrst_busy", busy, 1'b0);
        check("mrst_xy", {x_start, y_start}, 6'd0);
        check("mrst_abort", tour_abort, 1'b0);
        check("mrst_cnt", dut.move_cnt, 6'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
